// File: rtl/aer_pkg.sv
// Shared types and helpers for the AER readout path: encoder state, default widths
// and the priority encoder used to pick the next spike address.
package aer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int AER_TS_W   = 8;
   localparam int AER_ADDR_W = 3;
   localparam int EV_W       = AER_TS_W + AER_ADDR_W;

   // Widest spike vector the priority encoder accepts; narrower masks are zero-extended.
   localparam int MAX_N = 256;

   function automatic int lowest_set_index(input logic [MAX_N-1:0] vec);
      int idx;
      idx = 0;
      for (int i = MAX_N - 1; i >= 0; i--) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/aer_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// Pushes are refused while full, even if a pop happens in the same cycle.
module aer_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (push_ok && !pop_ok)
         count_next = count + (AW+1)'(1);
      else if (pop_ok && !push_ok)
         count_next = count - (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == (AW+1)'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   // Storage is data only; stale entries are masked by the empty flag.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spike_aer_encoder.sv
// Captures a neuron spike vector per timestep and serialises each set bit into an
// AER word {timestep, address}, lowest address first, through an event FIFO.
module spike_aer_encoder
   import aer_pkg::*;
#(
   parameter int N_NEURONS  = 8,
   parameter int ADDR_W     = AER_ADDR_W,
   parameter int TS_W       = AER_TS_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   step,
   input  logic [N_NEURONS-1:0]   spikes,
   output logic                   ev_valid,
   input  logic                   ev_ready,
   output logic [TS_W+ADDR_W-1:0] ev_data,
   output logic                   busy,
   output logic [CNT_W-1:0]       overrun_cnt
);

   state_t                 state;
   state_t                 state_next;
   logic [N_NEURONS-1:0]   mask;
   logic [N_NEURONS-1:0]   mask_next;
   logic [N_NEURONS-1:0]   mask_cleared;
   logic [TS_W-1:0]        ts;
   logic [TS_W-1:0]        ts_lat;
   logic [ADDR_W-1:0]      addr;
   logic [TS_W+ADDR_W-1:0] push_data;
   logic                   capture;
   logic                   push;
   logic                   drop;
   logic                   fifo_full;
   logic                   fifo_empty;

   assign addr         = ADDR_W'(lowest_set_index(MAX_N'(mask)));
   assign mask_cleared = mask & (mask - N_NEURONS'(1));
   assign push_data    = {ts_lat, addr};
   assign ev_valid     = ~fifo_empty;
   assign busy         = (state == SCAN);

   always_comb begin
      state_next = state;
      mask_next  = mask;
      capture    = 1'b0;
      push       = 1'b0;
      drop       = 1'b0;
      case (state)
         IDLE: begin
            if (step && (spikes != '0)) begin
               capture    = 1'b1;
               mask_next  = spikes;
               state_next = SCAN;
            end
         end
         SCAN: begin
            // Any step arriving mid-scan, including on the final push, is lost.
            drop = step;
            if (!fifo_full) begin
               push      = 1'b1;
               mask_next = mask_cleared;
               if (mask_cleared == '0) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         mask        <= '0;
         ts          <= '0;
         ts_lat      <= '0;
         overrun_cnt <= '0;
      end else begin
         state <= state_next;
         mask  <= mask_next;
         if (capture) ts_lat <= ts;
         if (step)    ts     <= ts + TS_W'(1);
         if (drop && (overrun_cnt != '1))
            overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
   end

   aer_fifo #(
      .WIDTH (TS_W + ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (ev_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (ev_data)
   );

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: directed scenarios plus random traffic against a
// queue-based model of timesteps, pending spikes and buffered events.
module tb_spike_aer_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        step;
   logic [7:0]  spikes;
   logic        ev_valid;
   logic        ev_ready;
   logic [10:0] ev_data;
   logic        busy;
   logic [7:0]  overrun_cnt;

   int checks = 0;
   int errors = 0;

   int          m_ts;
   int          m_ovr;
   logic [10:0] m_fifo [$];
   logic [10:0] m_pend [$];

   spike_aer_encoder dut (
      .clk         (clk),
      .reset       (reset),
      .step        (step),
      .spikes      (spikes),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_data     (ev_data),
      .busy        (busy),
      .overrun_cnt (overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      m_ts  = 0;
      m_ovr = 0;
      m_fifo.delete();
      m_pend.delete();
   endtask

   // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
   task automatic tick(input logic s, input logic [7:0] sp, input logic rdy);
      bit          was_busy;
      bit          do_push;
      bit          do_pop;
      logic [10:0] w;
      step     = s;
      spikes   = sp;
      ev_ready = rdy;
      @(posedge clk);
      was_busy = (m_pend.size() > 0);
      do_push  = was_busy && (m_fifo.size() < 4);
      do_pop   = (m_fifo.size() > 0) && rdy;
      w = '0;
      if (do_push) w = m_pend.pop_front();
      if (do_pop)  void'(m_fifo.pop_front());
      if (do_push) m_fifo.push_back(w);
      if (s) begin
         if (was_busy) begin
            if (m_ovr < 255) m_ovr++;
         end else begin
            for (int i = 0; i < 8; i++)
               if (sp[i]) m_pend.push_back({m_ts[7:0], i[2:0]});
         end
         m_ts = (m_ts + 1) % 256;
      end
      #1;
      step = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      step = 1'b0; spikes = '0; ev_ready = 1'b0;
      reset = 1'b1;
      model_clear();
      #2;
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ev_valid); end
      checks++; if (ev_data !== 11'd0) begin errors++; $display("FAIL rst_data got %h want 0", ev_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL rst_ovr got %0d want 0", overrun_cnt); end
      @(posedge clk); #1; reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [10:0] exp_ev [3];
      exp_ev[0] = {8'd0, 3'd0}; exp_ev[1] = {8'd0, 3'd5}; exp_ev[2] = {8'd0, 3'd7};
      do_reset();
      tick(1'b1, 8'b1010_0001, 1'b1);
      checks++; if (ev_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_c1 got v=%b b=%b want v=0 b=1", ev_valid, busy); end
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 8'h00, 1'b1);
         checks++; if (ev_valid !== 1'b1 || ev_data !== exp_ev[k]) begin errors++; $display("FAIL basic_ev%0d got v=%b d=%h want v=1 d=%h", k, ev_valid, ev_data, exp_ev[k]); end
         checks++; if (busy !== (k < 2)) begin errors++; $display("FAIL basic_busy%0d got %b want %b", k, busy, k < 2); end
      end
      tick(1'b0, 8'h00, 1'b1);
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", ev_valid); end
   endtask

   task automatic test_backpressure();
      logic [10:0] held;
      int          n;
      do_reset();
      tick(1'b1, 8'hFF, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      held = ev_data;
      for (int k = 0; k < 8; k++) begin
         tick(1'b0, 8'h00, 1'b0);
         checks++; if (ev_data !== held) begin errors++; $display("FAIL bp_stable got %h want %h", ev_data, held); end
         checks++; if (busy !== (m_pend.size() > 0) || ev_valid !== (m_fifo.size() > 0)) begin errors++; $display("FAIL bp_state got b=%b v=%b want b=%b v=%b", busy, ev_valid, m_pend.size() > 0, m_fifo.size() > 0); end
      end
      checks++; if (busy !== 1'b1 || m_fifo.size() != 4) begin errors++; $display("FAIL bp_full got busy=%b want 1 (model occupancy %0d)", busy, m_fifo.size()); end
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (ev_valid === 1'b1) begin
            checks++; if (ev_data !== {8'd0, n[2:0]}) begin errors++; $display("FAIL bp_order got %h want %h", ev_data, {8'd0, n[2:0]}); end
            n++;
         end
         tick(1'b0, 8'h00, 1'b1);
      end
      checks++; if (n != 8) begin errors++; $display("FAIL bp_count got %0d want 8", n); end
   endtask

   task automatic test_overrun();
      logic [10:0] got [$];
      do_reset();
      tick(1'b1, 8'h03, 1'b1);
      tick(1'b1, 8'h04, 1'b1);
      for (int k = 0; k < 6; k++) begin
         if (ev_valid === 1'b1) got.push_back(ev_data);
         tick(1'b0, 8'h00, 1'b1);
      end
      checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL ovr_cnt got %0d want 1", overrun_cnt); end
      checks++; if (got.size() != 2) begin errors++; $display("FAIL ovr_nevents got %0d want 2", got.size()); end
      else begin
         checks++; if (got[0] !== 11'd0 || got[1] !== 11'd1) begin errors++; $display("FAIL ovr_events got %h %h want 000 001", got[0], got[1]); end
      end
      tick(1'b1, 8'h01, 1'b1);
      tick(1'b0, 8'h00, 1'b1);
      checks++; if (ev_valid !== 1'b1 || ev_data !== {8'd2, 3'd0}) begin errors++; $display("FAIL ovr_ts got v=%b d=%h want v=1 d=%h", ev_valid, ev_data, {8'd2, 3'd0}); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 256; k++) tick(1'b1, 8'h00, 1'b1);
      tick(1'b1, 8'h10, 1'b1);
      tick(1'b0, 8'h00, 1'b1);
      checks++; if (ev_valid !== 1'b1 || ev_data !== {8'd0, 3'd4}) begin errors++; $display("FAIL wrap_ev got v=%b d=%h want v=1 d=%h", ev_valid, ev_data, {8'd0, 3'd4}); end
      checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL wrap_ovr got %0d want 0", overrun_cnt); end
   endtask

   task automatic test_reset_mid_scan();
      int n;
      do_reset();
      tick(1'b1, 8'hFF, 1'b0);
      tick(1'b1, 8'hFF, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (busy !== 1'b1 || ev_valid !== 1'b1 || overrun_cnt !== 8'd1) begin errors++; $display("FAIL mid_pre got b=%b v=%b o=%0d want 1 1 1", busy, ev_valid, overrun_cnt); end
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      checks++; if (ev_valid !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin errors++; $display("FAIL mid_async got v=%b b=%b o=%0d want 0 0 0", ev_valid, busy, overrun_cnt); end
      @(posedge clk); #1; reset = 1'b0;
      n = 0;
      tick(1'b1, 8'h02, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (ev_valid === 1'b1) begin
            n++;
            checks++; if (ev_data !== {8'd0, 3'd1}) begin errors++; $display("FAIL mid_ev got %h want %h", ev_data, {8'd0, 3'd1}); end
         end
         tick(1'b0, 8'h00, 1'b1);
      end
      checks++; if (n != 1) begin errors++; $display("FAIL mid_count got %0d want 1", n); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int k = 0; k < 300; k++) begin
         tick(1'b1, 8'hFF, 1'b1);
         checks++; if (overrun_cnt !== m_ovr[7:0]) begin errors++; $display("FAIL sat_track got %0d want %0d", overrun_cnt, m_ovr); end
      end
      checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", overrun_cnt); end
   endtask

   task automatic test_random();
      logic [10:0] want;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         tick(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
         want = (m_fifo.size() > 0) ? m_fifo[0] : 11'd0;
         checks++; if (ev_valid !== (m_fifo.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", k, ev_valid, m_fifo.size() > 0); end
         checks++; if (ev_data !== want) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", k, ev_data, want); end
         checks++; if (busy !== (m_pend.size() > 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", k, busy, m_pend.size() > 0); end
         checks++; if (overrun_cnt !== m_ovr[7:0]) begin errors++; $display("FAIL rnd_ovr cyc %0d got %0d want %0d", k, overrun_cnt, m_ovr); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overrun();
      test_wrap();
      test_reset_mid_scan();
      test_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
Downstream consumer of the LIF neuron array. Samples the neurons' per-timestep spike vector and serialises every spike into an Address-Event Representation (AER) word {timestep, neuron address}. Events are buffered in a small FIFO and emitted on a valid/ready stream toward the uio/uo pin mux or a host readout. Lost timesteps are counted so the host can detect overrun.

Parameters:
N_NEURONS, 8, number of spike input lines (neuron count)
ADDR_W, 3, address width; must equal clog2(N_NEURONS)
TS_W, 8, timestep counter width
FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2
CNT_W, 8, overrun counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
step  input  1  one-cycle strobe; spikes is valid on this cycle (one neuron timestep)
spikes  input  N_NEURONS  spike vector from the neuron array, bit i = neuron i
ev_valid  output  1  event word available
ev_ready  input  1  consumer accepts the word when ev_valid and ev_ready are both high
ev_data  output  TS_W+ADDR_W  {timestep[TS_W-1:0], addr[ADDR_W-1:0]}
busy  output  1  high while a captured vector is being scanned (state SCAN)
overrun_cnt  output  CNT_W  saturating count of dropped timesteps

Behaviour:
- Reset (asynchronous, active-high). Clears ts, the pending mask, the FIFO pointers and overrun_cnt. State = IDLE.
- Output values in reset: ev_valid=0, ev_data=0, busy=0, overrun_cnt=0.
- Timestep counter ts:
  - increments by 1 on every step, whether or not that step is accepted
  - wraps modulo 2^TS_W
  - the value captured with a vector is ts before the increment (first step after reset carries ts=0)
- IDLE state:
  - step with spikes!=0: latch mask<=spikes and ts_lat<=ts, go to SCAN
  - step with spikes==0: ts advances only, stay in IDLE
- SCAN state, each cycle:
  - if the FIFO is not full: push {ts_lat, index of lowest set bit of mask} and clear that bit
  - if the cleared bit was the last set bit: go to IDLE in the same edge
  - if the FIFO is full: stall; mask is unchanged
- Step received while in SCAN, including the cycle of the final push:
  - vector dropped
  - overrun_cnt += 1, saturating at 2^CNT_W-1
  - ts still increments
- Ordering: within one timestep, events are emitted in ascending address order. Timesteps are emitted in capture order.
- Throughput: 1 event per cycle when not back-pressured.
- Latency: step at cycle 0 with only bit k set -> ev_valid high in cycle 2 with ev_data={0,k}, assuming the FIFO is empty and ts=0.
- FIFO:
  - first-word-fall-through; ev_valid = !empty; ev_data = head entry
  - pop on ev_valid & ev_ready
  - push is gated by a registered full flag only; a push is refused when full even if a pop happens in the same cycle (no combinational ready path)
  - simultaneous push and pop when not full: occupancy unchanged
  - ev_data is stable while ev_valid=1 and ev_ready=0
- busy = (state==SCAN). Registered, glitch-free.
- Reset asserted mid-scan or with a non-empty FIFO: all pending and buffered events are discarded. No event is emitted until a new step is captured after reset is released.

Decomposition:
- Package aer_pkg:
  - state enum {IDLE, SCAN}
  - localparam EV_W = TS_W+ADDR_W
  - function lowest_set_index (priority encoder)
- Sub-module aer_fifo: parameterised width/depth, FWFT, registered full/empty. Reusable by later readout stages.
- The encoder FSM, ts counter and overrun counter stay in spike_aer_encoder.

Test Plan:
- Reset, then step with spikes=8'b1010_0001 and ev_ready=1 -> events {0,0},{0,5},{0,7} on consecutive cycles; first event 2 cycles after step; busy high for 3 cycles.
- ev_ready=0 held, step with spikes=8'hFF -> 4 events buffered, busy stays high and mask stalls. Release ev_ready -> all 8 addresses 0..7 emitted in order with ts=0, none lost, ev_data stable while stalled.
- Step spikes=8'h03, then step again 1 cycle later with spikes=8'h04 -> second step dropped, overrun_cnt=1, only addresses 0,1 emitted. A third step after IDLE yields ts=2.
- 256 steps with spikes=0, then step with spikes=8'h10 -> event {0,4}, confirming ts wrap; overrun_cnt stays 0.
- Assert reset while in SCAN with 3 words in the FIFO -> ev_valid=0, busy=0, overrun_cnt=0 immediately (asynchronous). Next step with spikes=8'h02 -> single event {0,1}.
- 300 back-to-back steps with spikes=8'hFF -> overrun_cnt saturates at 255 and does not wrap.
